// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// FSM states and op classification helpers.
package md_pkg;

  typedef enum logic [3:0] {
    NONE  = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8,
    MADD  = 4'd9,
    MADDU = 4'd10,
    MSUB  = 4'd11,
    MSUBU = 4'd12
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DFIX = 2'd3
  } md_state_e;

  function automatic logic is_start(input logic [3:0] op);
    return op inside {MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return op inside {MULT, MADD, MSUB, DIV};
  endfunction

endpackage

// File: rtl/md_unit_iter_if.sv
// Pipeline-side port bundle of the multiply/divide unit.
interface md_unit_iter_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic [WIDTH-1:0] out;

  modport master (output flush, op, rs, rt, input busy, out);
  modport slave  (input flush, op, rs, rt, output busy, out);
endinterface

// File: rtl/md_div_iter.sv
// Unsigned restoring divider core: one quotient bit per cycle, WIDTH cycles
// after start. done flags the cycle whose closing edge produces the result.
module md_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             running;
  logic [IW-1:0]    iter;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   shifted;
  logic             ge;

  // quo doubles as the dividend shift register; quotient bits enter at the bottom
  assign shifted = {rem, quo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvsr};
  assign done    = running && (iter == IW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      iter    <= '0;
      quo     <= '0;
      rem     <= '0;
      dvsr    <= '0;
    end else if (kill) begin
      running <= 1'b0;
      iter    <= '0;
    end else if (start) begin
      running <= 1'b1;
      iter    <= '0;
      quo     <= dividend;
      rem     <= '0;
      dvsr    <= divisor;
    end else if (running) begin
      rem     <= ge ? (shifted[WIDTH-1:0] - dvsr) : shifted[WIDTH-1:0];
      quo     <= {quo[WIDTH-2:0], ge};
      iter    <= iter + IW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/md_unit_iter.sv
// EX-stage multiply/divide unit owning HI/LO: fixed-latency multiply and
// multiply-accumulate, iterative divide with sign fix-up, flushable.
module md_unit_iter
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input logic           clk,
  input logic           rst,
  md_unit_iter_if.slave bus
);

  localparam int CW = $clog2(MUL_LAT + 1);

  md_state_e          state;
  md_op_e             op;
  logic [WIDTH-1:0]   hi, lo;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mul_res;
  logic               q_neg, r_neg, div_zero;
  logic [WIDTH-1:0]   rs_orig;

  logic               idle_take, sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;
  logic               div_start, div_done;
  logic [WIDTH-1:0]   abs_rs, abs_rt, div_quo, div_rem;

  assign op        = md_op_e'(bus.op);
  assign idle_take = (state == ST_IDLE) && !bus.flush;
  assign sgn       = is_signed_op(bus.op);

  // Low 2*WIDTH bits of the extended product are exact for both signednesses
  always_comb begin
    ext_a = {{WIDTH{sgn & bus.rs[WIDTH-1]}}, bus.rs};
    ext_b = {{WIDTH{sgn & bus.rt[WIDTH-1]}}, bus.rt};
    prod  = ext_a * ext_b;
    acc   = prod;
    if (op == MADD || op == MADDU)      acc = {hi, lo} + prod;
    else if (op == MSUB || op == MSUBU) acc = {hi, lo} - prod;
  end

  assign abs_rs    = (sgn && bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
  assign abs_rt    = (sgn && bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;
  assign div_start = idle_take && (op == DIV || op == DIVU);

  md_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .kill     (bus.flush),
    .dividend (abs_rs),
    .divisor  (abs_rt),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  assign bus.busy = (state != ST_IDLE) || is_start(bus.op);

  always_comb begin
    bus.out = '0;
    if (op == MFHI)      bus.out = hi;
    else if (op == MFLO) bus.out = lo;
  end

  // Control FSM; flush anywhere outside IDLE abandons the op without commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      mul_res  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      rs_orig  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (idle_take) begin
            if (op == MTHI) hi <= bus.rs;
            else if (op == MTLO) lo <= bus.rs;
            else if (is_mul(bus.op)) begin
              mul_res <= acc;
              cnt     <= CW'(MUL_LAT);
              state   <= ST_MUL;
            end else if (op == DIV || op == DIVU) begin
              q_neg    <= sgn & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
              r_neg    <= sgn & bus.rs[WIDTH-1];
              div_zero <= (bus.rt == '0);
              rs_orig  <= bus.rs;
              state    <= ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (bus.flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            {hi, lo} <= mul_res;
            cnt      <= '0;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DIV: begin
          if (bus.flush)     state <= ST_IDLE;
          else if (div_done) state <= ST_DFIX;
        end
        ST_DFIX: begin
          if (!bus.flush) begin
            hi <= div_zero ? rs_orig : (r_neg ? -div_rem : div_rem);
            lo <= div_zero ? '1      : (q_neg ? -div_quo : div_quo);
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
